// File: rtl/risc_toy_pkg.sv
// Shared definitions for the RISC_TOY core and its memory-side responder:
// opcode numbering, data read/write encoding and loader FSM state codes.
package risc_toy_pkg;

    localparam logic [4:0] ADDI = 5'd0;
    localparam logic [4:0] ANDI = 5'd1;
    localparam logic [4:0] ORI  = 5'd2;
    localparam logic [4:0] MOVI = 5'd3;
    localparam logic [4:0] ADD  = 5'd4;
    localparam logic [4:0] SUB  = 5'd5;
    localparam logic [4:0] NEG  = 5'd6;
    localparam logic [4:0] NOT  = 5'd7;
    localparam logic [4:0] AND  = 5'd8;
    localparam logic [4:0] OR   = 5'd9;
    localparam logic [4:0] XOR  = 5'd10;
    localparam logic [4:0] LSR  = 5'd11;
    localparam logic [4:0] ASR  = 5'd12;
    localparam logic [4:0] SHL  = 5'd13;
    localparam logic [4:0] ROR  = 5'd14;
    localparam logic [4:0] BR   = 5'd15;
    localparam logic [4:0] BRL  = 5'd16;
    localparam logic [4:0] J    = 5'd17;
    localparam logic [4:0] JL   = 5'd18;
    localparam logic [4:0] LD   = 5'd19;
    localparam logic [4:0] LDR  = 5'd20;
    localparam logic [4:0] ST   = 5'd21;
    localparam logic [4:0] STR  = 5'd22;

    localparam logic DRW_READ  = 1'b0;
    localparam logic DRW_WRITE = 1'b1;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/risc_toy_sat_counter.sv
// CW-bit event counter that sticks at all-ones instead of wrapping.
module risc_toy_sat_counter #(
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/risc_toy_mem_responder.sv
// Unified instruction/data memory for RISC_TOY: a boot loader streams the
// program in, then the core is released and served with zero-latency reads.
module risc_toy_mem_responder
    import risc_toy_pkg::*;
#(
    parameter int AW         = 10,
    parameter bit PRELOAD_EN = 1'b1,
    parameter int CW         = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IREQ,
    input  logic [29:0]   IADDR,
    output logic [31:0]   INSTR,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [29:0]   DADDR,
    input  logic [31:0]   DWDATA,
    output logic [31:0]   DRDATA,
    input  logic          LD_VALID,
    input  logic [31:0]   LD_DATA,
    input  logic          LD_LAST,
    output logic          LD_READY,
    output logic          CORE_RSTN,
    output logic          ERR,
    output logic [CW-1:0] IF_CNT,
    output logic [CW-1:0] RD_CNT,
    output logic [CW-1:0] WR_CNT
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [0:0] ST_RESET = PRELOAD_EN ? ST_LOAD : ST_RUN;

    logic [31:0]   mem_q [DEPTH];
    logic [0:0]    state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic          err_q, err_d;
    logic          ld_ready_q, ld_ready_d;
    logic          core_rstn_q, core_rstn_d;

    logic          run;
    logic          ld_fire;
    logic          ptr_full;
    logic          i_in_range;
    logic          d_in_range;
    logic          i_hit;
    logic          d_rd;
    logic          d_wr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    assign run        = (state_q == ST_RUN);
    assign ld_fire    = LD_VALID & ld_ready_q;
    assign ptr_full   = ptr_q[AW];
    assign i_in_range = (IADDR[29:AW] == '0);
    assign d_in_range = (DADDR[29:AW] == '0);
    assign i_hit      = run & IREQ & i_in_range;
    assign d_rd       = run & DREQ & (DRW == DRW_READ) & d_in_range;
    assign d_wr       = run & DREQ & (DRW == DRW_WRITE) & d_in_range;

    // Reads see the array as it was before this edge, so a same-cycle write
    // to the fetched address is only visible from the following cycle.
    assign INSTR  = i_hit ? mem_q[IADDR[AW-1:0]] : '0;
    assign DRDATA = d_rd ? mem_q[DADDR[AW-1:0]] : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q[AW-1:0];
        mem_wdata = LD_DATA;

        if (ld_fire) begin
            if (ptr_full) begin
                err_d = 1'b1;
            end else begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + (AW+1)'(1);
            end
            if (LD_LAST) begin
                state_d = ST_RUN;
            end
        end

        // Loader and core writes never coincide: ld_ready_q is only set in LOAD.
        if (d_wr) begin
            mem_we    = 1'b1;
            mem_waddr = DADDR[AW-1:0];
            mem_wdata = DWDATA;
        end

        if (run && ((IREQ && !i_in_range) || (DREQ && !d_in_range))) begin
            err_d = 1'b1;
        end

        ld_ready_d  = (state_d == ST_LOAD);
        core_rstn_d = run;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_RESET;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            ld_ready_q  <= 1'b0;
            core_rstn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            ld_ready_q  <= ld_ready_d;
            core_rstn_q <= core_rstn_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    risc_toy_sat_counter #(.CW(CW)) u_if_cnt (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .en_i  (run & IREQ),
        .cnt_o (IF_CNT)
    );

    risc_toy_sat_counter #(.CW(CW)) u_rd_cnt (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .en_i  (run & DREQ & (DRW == DRW_READ)),
        .cnt_o (RD_CNT)
    );

    risc_toy_sat_counter #(.CW(CW)) u_wr_cnt (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .en_i  (run & DREQ & (DRW == DRW_WRITE)),
        .cnt_o (WR_CNT)
    );

    assign LD_READY  = ld_ready_q;
    assign CORE_RSTN = core_rstn_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_risc_toy_mem_responder.sv
// Directed bench for risc_toy_mem_responder: a full-size instance, a tiny
// AW=2/CW=4 instance for overflow and saturation, and a no-preload instance.
module tb_risc_toy_mem_responder;
    import risc_toy_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- full-size instance ----------------
    logic        b_rstn, b_ireq, b_dreq, b_drw, b_ld_valid, b_ld_last;
    logic [29:0] b_iaddr, b_daddr;
    logic [31:0] b_dwdata, b_ld_data, b_instr, b_drdata;
    logic        b_ld_ready, b_core_rstn, b_err;
    logic [15:0] b_if_cnt, b_rd_cnt, b_wr_cnt;

    risc_toy_mem_responder #(.AW(10), .PRELOAD_EN(1'b1), .CW(16)) u_big (
        .CLK(clk), .RSTN(b_rstn),
        .IREQ(b_ireq), .IADDR(b_iaddr), .INSTR(b_instr),
        .DREQ(b_dreq), .DRW(b_drw), .DADDR(b_daddr), .DWDATA(b_dwdata), .DRDATA(b_drdata),
        .LD_VALID(b_ld_valid), .LD_DATA(b_ld_data), .LD_LAST(b_ld_last), .LD_READY(b_ld_ready),
        .CORE_RSTN(b_core_rstn), .ERR(b_err),
        .IF_CNT(b_if_cnt), .RD_CNT(b_rd_cnt), .WR_CNT(b_wr_cnt)
    );

    // ---------------- small instance ----------------
    logic        s_rstn, s_ireq, s_dreq, s_drw, s_ld_valid, s_ld_last;
    logic [29:0] s_iaddr, s_daddr;
    logic [31:0] s_dwdata, s_ld_data, s_instr, s_drdata;
    logic        s_ld_ready, s_core_rstn, s_err;
    logic [3:0]  s_if_cnt, s_rd_cnt, s_wr_cnt;

    risc_toy_mem_responder #(.AW(2), .PRELOAD_EN(1'b1), .CW(4)) u_small (
        .CLK(clk), .RSTN(s_rstn),
        .IREQ(s_ireq), .IADDR(s_iaddr), .INSTR(s_instr),
        .DREQ(s_dreq), .DRW(s_drw), .DADDR(s_daddr), .DWDATA(s_dwdata), .DRDATA(s_drdata),
        .LD_VALID(s_ld_valid), .LD_DATA(s_ld_data), .LD_LAST(s_ld_last), .LD_READY(s_ld_ready),
        .CORE_RSTN(s_core_rstn), .ERR(s_err),
        .IF_CNT(s_if_cnt), .RD_CNT(s_rd_cnt), .WR_CNT(s_wr_cnt)
    );

    // ---------------- no-preload instance ----------------
    logic        n_rstn, n_ireq, n_dreq, n_drw, n_ld_valid, n_ld_last;
    logic [29:0] n_iaddr, n_daddr;
    logic [31:0] n_dwdata, n_ld_data, n_instr, n_drdata;
    logic        n_ld_ready, n_core_rstn, n_err;
    logic [7:0]  n_if_cnt, n_rd_cnt, n_wr_cnt;

    risc_toy_mem_responder #(.AW(4), .PRELOAD_EN(1'b0), .CW(8)) u_nopre (
        .CLK(clk), .RSTN(n_rstn),
        .IREQ(n_ireq), .IADDR(n_iaddr), .INSTR(n_instr),
        .DREQ(n_dreq), .DRW(n_drw), .DADDR(n_daddr), .DWDATA(n_dwdata), .DRDATA(n_drdata),
        .LD_VALID(n_ld_valid), .LD_DATA(n_ld_data), .LD_LAST(n_ld_last), .LD_READY(n_ld_ready),
        .CORE_RSTN(n_core_rstn), .ERR(n_err),
        .IF_CNT(n_if_cnt), .RD_CNT(n_rd_cnt), .WR_CNT(n_wr_cnt)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic        ireq;
        logic [29:0] iaddr;
        logic        dreq;
        logic        drw;
        logic [29:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] exp_instr;
        logic [31:0] exp_drdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    // ---------------- checker / drivers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic b_load(input logic [31:0] data, input logic last);
        b_ld_valid = 1'b1;
        b_ld_data  = data;
        b_ld_last  = last;
        #1;
        check("b_ld_ready_in_load", 32'(b_ld_ready), 32'd1);
        check("b_instr_in_load", b_instr, 32'h0);
        check("b_drdata_in_load", b_drdata, 32'h0);
        @(negedge clk);
    endtask

    task automatic s_load(input logic [31:0] data, input logic last);
        s_ld_valid = 1'b1;
        s_ld_data  = data;
        s_ld_last  = last;
        #1;
        check("s_ld_ready_in_load", 32'(s_ld_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic s_fetch(input logic [29:0] addr);
        s_ireq  = 1'b1;
        s_iaddr = addr;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // RUN-phase vectors for the full-size instance, one cycle each
        vecs[0]  = '{1'b1, 30'h2,   1'b0, DRW_READ,  30'h0,   32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 30'h0,   1'b1, DRW_READ,  30'h1,   32'h0,        32'h18400005, 32'h00000001, 1'b0};
        vecs[2]  = '{1'b0, 30'h0,   1'b1, DRW_WRITE, 30'h10,  32'hA5A5A5A5, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b1, 30'h3,   1'b1, DRW_READ,  30'h10,  32'h0,        32'h12345678, 32'hA5A5A5A5, 1'b0};
        vecs[4]  = '{1'b1, 30'h10,  1'b1, DRW_WRITE, 30'h10,  32'h11111111, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 30'h10,  1'b0, DRW_READ,  30'h0,   32'h0,        32'h11111111, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 30'h0,   1'b1, DRW_READ,  30'h400, 32'h0,        32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b0, 30'h0,   1'b0, DRW_READ,  30'h0,   32'h0,        32'h0,        32'h0,        1'b1};
        vecs[8]  = '{1'b0, 30'h0,   1'b1, DRW_WRITE, 30'h400, 32'hCAFEF00D, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{1'b1, 30'h0,   1'b0, DRW_READ,  30'h0,   32'h0,        32'h18400005, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 30'h400, 1'b0, DRW_READ,  30'h0,   32'h0,        32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b0, 30'h0,   1'b0, DRW_READ,  30'h0,   32'h0,        32'h0,        32'h0,        1'b1};

        {b_rstn, b_ireq, b_dreq, b_drw, b_ld_valid, b_ld_last} = '0;
        {b_iaddr, b_daddr, b_dwdata, b_ld_data} = '0;
        {s_rstn, s_ireq, s_dreq, s_drw, s_ld_valid, s_ld_last} = '0;
        {s_iaddr, s_daddr, s_dwdata, s_ld_data} = '0;
        {n_rstn, n_ireq, n_dreq, n_drw, n_ld_last} = '0;
        {n_iaddr, n_daddr, n_dwdata, n_ld_data} = '0;
        n_ld_valid = 1'b1;

        // ---- reset values ----
        #1;
        check("b_rst_core_rstn", 32'(b_core_rstn), 32'd0);
        check("b_rst_ld_ready", 32'(b_ld_ready), 32'd0);
        check("b_rst_err", 32'(b_err), 32'd0);
        check("b_rst_if_cnt", 32'(b_if_cnt), 32'd0);
        check("n_rst_core_rstn", 32'(n_core_rstn), 32'd0);
        check("n_rst_ld_ready", 32'(n_ld_ready), 32'd0);

        // ---- full-size: boot load, core requests ignored meanwhile ----
        repeat (2) @(negedge clk);
        b_rstn   = 1'b1;
        b_ireq   = 1'b1;
        b_dreq   = 1'b1;
        b_drw    = DRW_WRITE;
        b_daddr  = 30'h1;
        b_dwdata = 32'h00000BAD;
        @(negedge clk);
        b_load(32'h18400005, 1'b0);
        b_load(32'h00000001, 1'b0);
        b_load(32'hDEADBEEF, 1'b0);
        b_load(32'h12345678, 1'b1);
        b_ld_valid = 1'b0;
        b_ld_last  = 1'b0;
        b_ireq     = 1'b0;
        b_dreq     = 1'b0;
        #1;
        check("b_ld_ready_after_last", 32'(b_ld_ready), 32'd0);
        check("b_core_rstn_entry_cycle", 32'(b_core_rstn), 32'd0);
        check("b_err_after_load", 32'(b_err), 32'd0);
        check("b_wr_cnt_load_ignored", 32'(b_wr_cnt), 32'd0);
        check("b_if_cnt_load_ignored", 32'(b_if_cnt), 32'd0);
        @(negedge clk);
        #1;
        check("b_core_rstn_released", 32'(b_core_rstn), 32'd1);
        @(negedge clk);

        // ---- full-size: table-driven RUN vectors ----
        for (int i = 0; i < 12; i++) begin
            b_ireq   = vecs[i].ireq;
            b_iaddr  = vecs[i].iaddr;
            b_dreq   = vecs[i].dreq;
            b_drw    = vecs[i].drw;
            b_daddr  = vecs[i].daddr;
            b_dwdata = vecs[i].dwdata;
            #1;
            check($sformatf("vec%0d_instr", i), b_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_drdata", i), b_drdata, vecs[i].exp_drdata);
            check($sformatf("vec%0d_err", i), 32'(b_err), 32'(vecs[i].exp_err));
            @(negedge clk);
        end
        b_ireq = 1'b0;
        b_dreq = 1'b0;
        #1;
        check("b_if_cnt", 32'(b_if_cnt), 32'd7);
        check("b_rd_cnt", 32'(b_rd_cnt), 32'd3);
        check("b_wr_cnt", 32'(b_wr_cnt), 32'd3);
        check("b_core_rstn_run", 32'(b_core_rstn), 32'd1);

        // ---- full-size: async reset mid-RUN, array survives ----
        #2 b_rstn = 1'b0;
        #1;
        check("b_midrun_rst_core_rstn", 32'(b_core_rstn), 32'd0);
        check("b_midrun_rst_err", 32'(b_err), 32'd0);
        check("b_midrun_rst_if_cnt", 32'(b_if_cnt), 32'd0);
        check("b_midrun_rst_wr_cnt", 32'(b_wr_cnt), 32'd0);
        @(negedge clk);
        b_rstn = 1'b1;
        @(negedge clk);
        b_load(32'h77777777, 1'b1);
        b_ld_valid = 1'b0;
        b_ld_last  = 1'b0;
        b_ireq     = 1'b1;
        b_iaddr    = 30'h0;
        #1;
        check("b_reload_at_ptr0", b_instr, 32'h77777777);
        b_iaddr = 30'h2;
        #1;
        check("b_array_kept", b_instr, 32'hDEADBEEF);
        b_iaddr = 30'h10;
        #1;
        check("b_array_kept_write", b_instr, 32'h11111111);
        @(negedge clk);
        b_ireq = 1'b0;

        // ---- small: async reset mid-LOAD after two words ----
        s_rstn = 1'b1;
        @(negedge clk);
        s_load(32'h000000A0, 1'b0);
        s_load(32'h000000A1, 1'b0);
        s_ld_valid = 1'b0;
        #2 s_rstn = 1'b0;
        #1;
        check("s_midload_rst_ld_ready", 32'(s_ld_ready), 32'd0);
        check("s_midload_rst_core_rstn", 32'(s_core_rstn), 32'd0);
        @(negedge clk);
        s_rstn = 1'b1;
        @(negedge clk);

        // ---- small: loader overflow, five words into four slots ----
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                #1;
                check("s_err_before_overflow", 32'(s_err), 32'd0);
            end
            s_load(32'(i + 1), (i == 4));
        end
        s_ld_valid = 1'b0;
        s_ld_last  = 1'b0;
        #1;
        check("s_err_overflow", 32'(s_err), 32'd1);
        check("s_ld_ready_after_last", 32'(s_ld_ready), 32'd0);
        check("s_core_rstn_entry_cycle", 32'(s_core_rstn), 32'd0);

        // ---- small: contents, then counter saturation ----
        for (int i = 0; i < 4; i++) begin
            s_ireq  = 1'b1;
            s_iaddr = 30'(i);
            #1;
            check($sformatf("s_mem%0d", i), s_instr, 32'(i + 1));
            @(negedge clk);
        end
        s_ireq = 1'b0;
        #1;
        check("s_if_cnt_4", 32'(s_if_cnt), 32'd4);
        check("s_err_sticky", 32'(s_err), 32'd1);
        for (int i = 0; i < 10; i++) s_fetch(30'h0);
        s_ireq = 1'b0;
        #1;
        check("s_if_cnt_14", 32'(s_if_cnt), 32'd14);
        for (int i = 0; i < 6; i++) s_fetch(30'h0);
        s_ireq = 1'b0;
        #1;
        check("s_if_cnt_saturated", 32'(s_if_cnt), 32'd15);

        // ---- no-preload: straight to RUN, loader ignored ----
        @(negedge clk);
        n_rstn = 1'b1;
        #1;
        check("n_core_rstn_before_edge", 32'(n_core_rstn), 32'd0);
        @(negedge clk);
        #1;
        check("n_core_rstn_first_edge", 32'(n_core_rstn), 32'd1);
        check("n_ld_ready", 32'(n_ld_ready), 32'd0);
        n_dreq   = 1'b1;
        n_drw    = DRW_WRITE;
        n_daddr  = 30'h3;
        n_dwdata = 32'h5555AAAA;
        #1;
        check("n_drdata_write_cycle", n_drdata, 32'h0);
        @(negedge clk);
        n_drw = DRW_READ;
        #1;
        check("n_drdata_read", n_drdata, 32'h5555AAAA);
        @(negedge clk);
        n_dreq = 1'b0;
        #1;
        check("n_wr_cnt", 32'(n_wr_cnt), 32'd1);
        check("n_rd_cnt", 32'(n_rd_cnt), 32'd1);
        check("n_err", 32'(n_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
